// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and
// fetch/stall event counters. Priority on each edge is
// reset > branch redirect > stall hold > normal sequential fetch.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] imem_data,
    output logic [31:0] imem_addr,
    output logic [31:0] PC,
    output logic [31:0] IFID_instr,
    output logic [31:0] IFID_PC4,
    output logic        IFID_valid,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
);

    logic [31:0] pc_plus4;
    logic [31:0] target_aligned;

    // Sequential PC increment wraps modulo 2^32; misaligned targets are
    // silently word-aligned.
    always_comb begin
        pc_plus4       = PC + 32'd4;
        target_aligned = {branch_target[31:2], 2'b00};
        imem_addr      = PC;
    end

    // PC, IF/ID register and counters; outputs depend only on registered state.
    always_ff @(posedge clock) begin
        if (reset) begin
            PC          <= RESET_PC;
            IFID_instr  <= '0;
            IFID_PC4    <= '0;
            IFID_valid  <= 1'b0;
            fetch_count <= '0;
            stall_count <= '0;
        end else if (branch_taken) begin
            PC          <= target_aligned;
            IFID_instr  <= '0;
            IFID_PC4    <= pc_plus4;
            IFID_valid  <= 1'b0;
        end else if (stall) begin
            stall_count <= stall_count + 32'd1;
        end else begin
            PC          <= pc_plus4;
            IFID_instr  <= imem_data;
            IFID_PC4    <= pc_plus4;
            IFID_valid  <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, random
// stimulus against a rule-level reference model, and a wrap-around check
// on a second instance reset to the top of the address space.
module tb_fetch_stage;

    logic        clock = 1'b0;
    always #5 clock = ~clock;

    // Instruction memory contents as a pure function of the byte address.
    function automatic logic [31:0] imem_word(input logic [31:0] a);
        return a * 32'h9E37_79B1 + 32'h1357_9BDF;
    endfunction

    // Main instance, RESET_PC = 0
    logic        reset, stall, branch_taken;
    logic [31:0] branch_target, imem_data, imem_addr, PC;
    logic [31:0] IFID_instr, IFID_PC4, fetch_count, stall_count;
    logic        IFID_valid;

    assign imem_data = imem_word(imem_addr);

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clock(clock), .reset(reset), .stall(stall),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .imem_data(imem_data), .imem_addr(imem_addr), .PC(PC),
        .IFID_instr(IFID_instr), .IFID_PC4(IFID_PC4), .IFID_valid(IFID_valid),
        .fetch_count(fetch_count), .stall_count(stall_count)
    );

    // Wrap instance, RESET_PC = 0xFFFFFFFC
    logic        reset2, stall2, branch2;
    logic [31:0] target2, imem_data2, imem_addr2, PC2;
    logic [31:0] instr2, pc4_2, fc2, sc2;
    logic        valid2;

    assign imem_data2 = imem_word(imem_addr2);

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clock(clock), .reset(reset2), .stall(stall2),
        .branch_taken(branch2), .branch_target(target2),
        .imem_data(imem_data2), .imem_addr(imem_addr2), .PC(PC2),
        .IFID_instr(instr2), .IFID_PC4(pc4_2), .IFID_valid(valid2),
        .fetch_count(fc2), .stall_count(sc2)
    );

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic        rst, stl, br;
        logic [31:0] tgt;
        logic [31:0] pc, pc4, instr;
        logic        valid;
        logic [31:0] fc, sc;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic stl, input logic br,
                                input logic [31:0] tgt, input logic [31:0] pc,
                                input logic [31:0] pc4, input logic [31:0] instr,
                                input logic valid, input logic [31:0] fc,
                                input logic [31:0] sc);
        vec_t v;
        v.rst = rst; v.stl = stl; v.br = br; v.tgt = tgt;
        v.pc = pc; v.pc4 = pc4; v.instr = instr; v.valid = valid;
        v.fc = fc; v.sc = sc;
        tbl.push_back(v);
    endfunction

    // Reference model state, updated from the behavioural rules.
    logic [31:0] m_pc, m_pc4, m_instr, m_fc, m_sc;
    logic        m_valid;

    task automatic model_edge(input logic rst, input logic stl, input logic br,
                              input logic [31:0] tgt);
        logic [31:0] word;
        word = imem_word(m_pc);
        if (rst) begin
            m_pc = 0; m_pc4 = 0; m_instr = 0; m_valid = 0; m_fc = 0; m_sc = 0;
        end else if (br) begin
            m_pc4   = m_pc + 4;
            m_pc    = tgt - (tgt % 4);
            m_instr = 0;
            m_valid = 0;
        end else if (stl) begin
            m_sc = m_sc + 1;
        end else begin
            m_instr = word;
            m_pc    = m_pc + 4;
            m_pc4   = m_pc;
            m_valid = 1;
            m_fc    = m_fc + 1;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".PC"}, PC, m_pc);
        chk({tag, ".imem_addr"}, imem_addr, m_pc);
        chk({tag, ".IFID_instr"}, IFID_instr, m_instr);
        chk({tag, ".IFID_PC4"}, IFID_PC4, m_pc4);
        chk({tag, ".IFID_valid"}, {31'b0, IFID_valid}, {31'b0, m_valid});
        chk({tag, ".fetch_count"}, fetch_count, m_fc);
        chk({tag, ".stall_count"}, stall_count, m_sc);
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        reset2 = 1'b1; stall2 = 1'b0; branch2 = 1'b0; target2 = '0;

        // Directed table: two reset cycles, sequential fetch to PC=40,
        // stall, branches (incl. misaligned and stall+branch), mid-run reset.
        add(1,0,0,0, 0,0,0,0, 0,0);
        add(1,0,0,0, 0,0,0,0, 0,0);
        for (int unsigned i = 1; i <= 10; i++)
            add(0,0,0,0, 4*i, 4*i, imem_word(4*i-4), 1, i, 0);
        add(0,1,0,0,     40, 40, imem_word(36), 1, 10, 1);
        add(0,0,0,0,     44, 44, imem_word(40), 1, 11, 1);
        add(0,0,1,20,    20, 48, 0, 0, 11, 1);
        add(0,0,1,32'h46, 68, 24, 0, 0, 11, 1);
        add(0,0,0,0,     72, 72, imem_word(68), 1, 12, 1);
        add(0,1,1,8,      8, 76, 0, 0, 12, 1);
        for (int unsigned k = 1; k <= 13; k++)
            add(0,0,0,0, 8+4*k, 8+4*k, imem_word(4+4*k), 1, 12+k, 1);
        add(0,1,0,0,     60, 60, imem_word(56), 1, 25, 2);
        add(1,1,0,0,      0, 0, 0, 0, 0, 0);
        add(0,0,0,0,      4, 4, imem_word(0), 1, 1, 0);
        add(1,0,1,32'h100, 0, 0, 0, 0, 0, 0);
        add(0,0,0,0,      4, 4, imem_word(0), 1, 1, 0);

        foreach (tbl[i]) begin
            reset = tbl[i].rst; stall = tbl[i].stl;
            branch_taken = tbl[i].br; branch_target = tbl[i].tgt;
            @(posedge clock); #1;
            chk($sformatf("vec%0d.PC", i), PC, tbl[i].pc);
            chk($sformatf("vec%0d.imem_addr", i), imem_addr, tbl[i].pc);
            chk($sformatf("vec%0d.IFID_instr", i), IFID_instr, tbl[i].instr);
            chk($sformatf("vec%0d.IFID_PC4", i), IFID_PC4, tbl[i].pc4);
            chk($sformatf("vec%0d.IFID_valid", i), {31'b0, IFID_valid}, {31'b0, tbl[i].valid});
            chk($sformatf("vec%0d.fetch_count", i), fetch_count, tbl[i].fc);
            chk($sformatf("vec%0d.stall_count", i), stall_count, tbl[i].sc);
        end

        // Random phase: starts with a reset so the model is in sync.
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
        @(posedge clock); #1;
        model_edge(1'b1, 1'b0, 1'b0, 32'h0);
        check_model("rst");
        for (int unsigned c = 0; c < 2000; c++) begin
            reset         = ($urandom_range(0, 59) == 0);
            stall         = ($urandom_range(0, 3) == 0);
            branch_taken  = ($urandom_range(0, 5) == 0);
            branch_target = $urandom;
            // Control inputs changed mid-cycle must not disturb any output.
            #3;
            check_model($sformatf("comb%0d", c));
            @(posedge clock); #1;
            model_edge(reset, stall, branch_taken, branch_target);
            check_model($sformatf("rnd%0d", c));
        end

        // Wrap-around on the instance reset to 0xFFFFFFFC.
        chk("wrap.reset_PC", PC2, 32'hFFFF_FFFC);
        chk("wrap.reset_PC4", pc4_2, 32'h0);
        reset2 = 1'b0;
        @(posedge clock); #1;
        chk("wrap.PC", PC2, 32'h0);
        chk("wrap.imem_addr", imem_addr2, 32'h0);
        chk("wrap.IFID_PC4", pc4_2, 32'h0);
        chk("wrap.IFID_instr", instr2, imem_word(32'hFFFF_FFFC));
        chk("wrap.IFID_valid", {31'b0, valid2}, 32'h1);
        chk("wrap.fetch_count", fc2, 32'h1);
        chk("wrap.stall_count", sc2, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
